// File: rtl/knap_search.sv
// Exhaustive 5-item knapsack search: one candidate per SCAN cycle, best-value selection kept.
// Latency: done pulses 33 cycles after start is sampled; start is ignored while busy.
// Optional KNAP_SEARCH_EARLY_EXIT_EN: finish right after the first valid candidate.
module knap_search #(
    parameter logic [7:0] VAL_A      = 8'd4,
    parameter logic [7:0] VAL_B      = 8'd2,
    parameter logic [7:0] VAL_C      = 8'd2,
    parameter logic [7:0] VAL_D      = 8'd1,
    parameter logic [7:0] VAL_E      = 8'd10,
    parameter logic [7:0] WGT_A      = 8'd12,
    parameter logic [7:0] WGT_B      = 8'd1,
    parameter logic [7:0] WGT_C      = 8'd2,
    parameter logic [7:0] WGT_D      = 8'd1,
    parameter logic [7:0] WGT_E      = 8'd4,
    parameter logic [7:0] MIN_VALUE  = 8'd15,
    parameter logic [7:0] MAX_WEIGHT = 8'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [4:0] best_sel,
    output logic [7:0] best_value,
    output logic [7:0] best_weight,
    output logic [5:0] valid_count
);

`ifdef KNAP_SEARCH_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t     state;
    logic [4:0] cand;
    logic [7:0] cand_value;
    logic [7:0] cand_weight;
    logic       cand_ok;

    // Bit 4 selects item A down to bit 0 selecting item E.
    always_comb begin
        cand_value  = (cand[4] ? VAL_A : 8'd0) + (cand[3] ? VAL_B : 8'd0)
                    + (cand[2] ? VAL_C : 8'd0) + (cand[1] ? VAL_D : 8'd0)
                    + (cand[0] ? VAL_E : 8'd0);
        cand_weight = (cand[4] ? WGT_A : 8'd0) + (cand[3] ? WGT_B : 8'd0)
                    + (cand[2] ? WGT_C : 8'd0) + (cand[1] ? WGT_D : 8'd0)
                    + (cand[0] ? WGT_E : 8'd0);
        cand_ok     = (cand_value >= MIN_VALUE) && (cand_weight <= MAX_WEIGHT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cand        <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            best_sel    <= 5'd0;
            best_value  <= 8'd0;
            best_weight <= 8'd0;
            valid_count <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= SCAN;
                        busy        <= 1'b1;
                        cand        <= 5'd0;
                        found       <= 1'b0;
                        best_sel    <= 5'd0;
                        best_value  <= 8'd0;
                        best_weight <= 8'd0;
                        valid_count <= 6'd0;
                    end
                end
                SCAN: begin
                    cand <= cand + 5'd1;
                    if (cand_ok) begin
                        valid_count <= valid_count + 6'd1;
                        found       <= 1'b1;
                        // Strict compare keeps the lower-indexed candidate on ties.
                        if (!found || (cand_value > best_value)) begin
                            best_sel    <= cand;
                            best_value  <= cand_value;
                            best_weight <= cand_weight;
                        end
                    end
                    if ((cand == 5'd31) || (EARLY_EXIT && cand_ok)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/knap_search.md
KNAP_SEARCH -- requirements
Module: knap_search

Interface
REQ-001 SHALL have parameter VAL_A..VAL_E, default 4,2,2,1,10: 8-bit value of items A..E.
REQ-002 SHALL have parameter WGT_A..WGT_E, default 12,1,2,1,4: 8-bit weight of items A..E.
REQ-003 SHALL have parameter MIN_VALUE, default 15: minimum total value for a valid selection.
REQ-004 SHALL have parameter MAX_WEIGHT, default 15: maximum total weight for a valid selection.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: request a search; sampled only in IDLE.
REQ-008 SHALL have port busy, output, 1: high while in SCAN.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when results are final.
REQ-010 SHALL have port found, output, 1: at least one valid selection found.
REQ-011 SHALL have port best_sel, output, 5: best selection, bit4=A, bit3=B, bit2=C, bit1=D, bit0=E.
REQ-012 SHALL have port best_value, output, 8: total value of best_sel.
REQ-013 SHALL have port best_weight, output, 8: total weight of best_sel.
REQ-014 SHALL have port valid_count, output, 6: number of valid selections evaluated (0..32).

Function
REQ-015 SHALL implement states IDLE, SCAN, DONE; IDLE->SCAN on start; SCAN->DONE after the last candidate; DONE->IDLE unconditionally after one cycle.
REQ-016 SHALL, on IDLE->SCAN, clear found, best_sel, best_value, best_weight, valid_count, and load candidate counter with 0.
REQ-017 SHALL evaluate exactly one candidate per SCAN cycle, in ascending order 0..31, then increment the counter.
REQ-018 SHALL compute totals as 8-bit sums of the parameters of the selected items, with no wrap for legal parameters (each sum <= 255).
REQ-019 SHALL deem a candidate valid when total value >= MIN_VALUE and total weight <= MAX_WEIGHT.
REQ-020 SHALL, for each valid candidate, increment valid_count, set found, and replace best_* when found was 0 or when its value is strictly greater than best_value; ties keep the lower-indexed candidate.
REQ-021 SHALL leave SCAN after candidate 31 is evaluated; the 5-bit counter wraps 31->0 without effect.
REQ-022 SHALL assert done only in DONE; with start sampled in cycle 0, SCAN occupies cycles 1..32 and done is high in cycle 33.
REQ-023 SHALL ignore start while in SCAN or DONE.
REQ-024 SHALL hold found, best_*, and valid_count stable from DONE until the next IDLE->SCAN transition.

Reset
REQ-025 SHALL, while rst is high at a clock edge, enter IDLE and drive busy, done, found, best_sel, best_value, best_weight, and valid_count to 0.
REQ-026 SHALL abort an in-progress scan on rst without asserting done; rst has priority over start.

Configuration
REQ-027 SHALL recognise the macro KNAP_SEARCH_EARLY_EXIT_EN.
REQ-028 SHALL, with KNAP_SEARCH_EARLY_EXIT_EN defined, go from SCAN to DONE in the cycle after the first valid candidate is evaluated, so valid_count is at most 1; otherwise SCAN runs as in REQ-021.
REQ-029 SHALL, without KNAP_SEARCH_EARLY_EXIT_EN, scan all 32 candidates.

Verification
REQ-030 SHALL cover: defaults, start pulse -> done in cycle 33, found=1, valid_count=1, best_sel=5'b01111, best_value=15, best_weight=8.
REQ-031 SHALL cover: MIN_VALUE=0, MAX_WEIGHT=31 -> valid_count=32, best_sel=5'b11111, best_value=19, best_weight=20.
REQ-032 SHALL cover: MIN_VALUE=2, MAX_WEIGHT=2 -> valid_count=3, best_sel=5'b01010, best_value=3, best_weight=2.
REQ-033 SHALL cover: MIN_VALUE=20 -> done in cycle 33, found=0, valid_count=0, best_* all 0.
REQ-034 SHALL cover: rst in cycle 10 of a scan, with start held high in cycles 5..20 -> all outputs 0, no done pulse; a fresh start then reproduces REQ-030.
REQ-035 SHALL cover: KNAP_SEARCH_EARLY_EXIT_EN with defaults -> done in cycle 17, valid_count=1, best_sel=5'b01111.
